// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared ALU types and constants: serial-adder FSM state encoding,
//             slice width, slice-count helper and add/sub op encoding.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  // Serial adder control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits handled by one csea_level slice
  localparam int SLICE_W = 8;

  // ALU op encoding for the add/subtract unit
  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  // Number of slice passes needed for an operand of the given width
  function automatic int slice_count(input int width);
    return width / SLICE_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csea_level.sv
`default_nettype none
// ============================================================================
//  Module   : csea_level
//  Purpose  : One 8-bit carry-select adder level. The low half ripples, the
//             high half is precomputed for both carry-in values and selected
//             by the low-half carry.
//  Revision : 1.0  initial release
// ============================================================================
module csea_level
  import alu_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               c_in,
  output logic [SLICE_W-1:0] z,
  output logic               next_c_out
);

  localparam int H = SLICE_W / 2;

  logic [H:0] w_lo;
  logic [H:0] w_hi0;
  logic [H:0] w_hi1;

  // Low half ripples with the true carry; high half is computed both ways
  always_comb begin
    w_lo  = {1'b0, x[H-1:0]} + {1'b0, y[H-1:0]} + {{H{1'b0}}, c_in};
    w_hi0 = {1'b0, x[SLICE_W-1:H]} + {1'b0, y[SLICE_W-1:H]};
    w_hi1 = {1'b0, x[SLICE_W-1:H]} + {1'b0, y[SLICE_W-1:H]} + {{H{1'b0}}, 1'b1};
  end

  // Select the precomputed high half using the low-half carry
  always_comb begin
    z[H-1:0] = w_lo[H-1:0];
    if (w_lo[H]) begin
      z[SLICE_W-1:H] = w_hi1[H-1:0];
      next_c_out     = w_hi1[H];
    end else begin
      z[SLICE_W-1:H] = w_hi0[H-1:0];
      next_c_out     = w_hi0[H];
    end
  end

endmodule
`default_nettype wire

// File: rtl/csea_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : csea_serial_adder
//  Purpose  : Multi-cycle WIDTH-bit add/subtract. One SLICE_W-bit byte per
//             cycle (LSB first) passes through a single csea_level with the
//             registered carry. Request handshake in_valid/in_ready, result
//             handshake out_valid/out_ready, synchronous flush.
//  Options  : CSEA_SERIAL_FLAGS_EN adds zero (zf) and negative (nf) flags.
//  Revision : 1.0  initial release
// ============================================================================
module csea_serial_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             c_out,
  output logic             ovf
`ifdef CSEA_SERIAL_FLAGS_EN
  ,
  output logic             zf,
  output logic             nf
`endif
);

  localparam int N_SLICES = slice_count(WIDTH);
  localparam int CNT_W    = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N_SLICES - 1);

  state_e r_state;
  state_e w_state_nxt;

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic             r_carry;
  logic [WIDTH-1:0] r_z;
  logic             r_cout;
  logic             r_ovf;

  logic w_accept;
  logic w_step;
  logic w_last;

  logic [SLICE_W-1:0] w_xs [N_SLICES];
  logic [SLICE_W-1:0] w_ys [N_SLICES];
  logic [SLICE_W-1:0] w_x_slice;
  logic [SLICE_W-1:0] w_y_slice;
  logic [SLICE_W-1:0] w_slice_z;
  logic               w_next_c;
  logic               w_c_msb;

  // Break the operands into slice-sized pieces for the per-cycle mux
  for (genvar i = 0; i < N_SLICES; i++) begin : g_split
    assign w_xs[i] = r_x[i*SLICE_W +: SLICE_W];
    assign w_ys[i] = r_y[i*SLICE_W +: SLICE_W];
  end

  assign w_x_slice = w_xs[r_cnt];
  assign w_y_slice = w_ys[r_cnt];

  csea_level u_level (
    .x          (w_x_slice),
    .y          (w_y_slice),
    .c_in       (r_carry),
    .z          (w_slice_z),
    .next_c_out (w_next_c)
  );

  // Carry into the MSB is recovered from the MSB sum bit of the final slice
  assign w_c_msb = w_x_slice[SLICE_W-1] ^ w_y_slice[SLICE_W-1] ^ w_slice_z[SLICE_W-1];

  // State register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and datapath strobes; flush overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        w_last = (r_cnt == C_LAST);
        if (r_cnt == C_LAST) w_state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (flush) begin
      w_state_nxt = IDLE;
      w_accept    = 1'b0;
      w_step      = 1'b0;
      w_last      = 1'b0;
    end
  end

  // Operand capture, slice counter, running carry and final flags
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_x     <= '0;
      r_y     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_x     <= x;
      r_y     <= (op_sub == ALU_OP_SUB) ? ~y : y;
      r_carry <= op_sub;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_carry <= w_next_c;
      if (w_last) begin
        r_cout <= w_next_c;
        r_ovf  <= w_c_msb ^ w_next_c;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Each result byte is written only on the cycle its slice is processed
  for (genvar i = 0; i < N_SLICES; i++) begin : g_zreg
    always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b)                                r_z[i*SLICE_W +: SLICE_W] <= '0;
      else if (w_step && (r_cnt == CNT_W'(i)))   r_z[i*SLICE_W +: SLICE_W] <= w_slice_z;
    end
  end

`ifdef CSEA_SERIAL_FLAGS_EN
  logic r_zacc;
  logic r_zf;
  logic r_nf;

  // Zero flag is a running OR of slice results, resolved on the last slice
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_zacc <= 1'b0;
      r_zf   <= 1'b0;
      r_nf   <= 1'b0;
    end else if (w_accept) begin
      r_zacc <= 1'b0;
    end else if (w_step) begin
      r_zacc <= r_zacc | (|w_slice_z);
      if (w_last) begin
        r_zf <= ~(r_zacc | (|w_slice_z));
        r_nf <= w_slice_z[SLICE_W-1];
      end
    end
  end

  assign zf = r_zf;
  assign nf = r_nf;
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign z         = r_z;
  assign c_out     = r_cout;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_csea_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csea_serial_adder
//  Purpose  : Self-checking bench for csea_serial_adder: directed corner
//             cases, backpressure, flush, async reset and random operations
//             compared against an arithmetic reference model.
//  Options  : CSEA_SERIAL_FLAGS_EN also checks zf/nf.
//  Revision : 1.0  initial release
// ============================================================================
module tb_csea_serial_adder;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        in_valid;
  logic        in_ready;
  logic        op_sub;
  logic [63:0] x;
  logic [63:0] y;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] z;
  logic        c_out;
  logic        ovf;
`ifdef CSEA_SERIAL_FLAGS_EN
  logic        zf;
  logic        nf;
`endif

  int n_total = 0;
  int n_bad   = 0;

  csea_serial_adder #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .x         (x),
    .y         (y),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .c_out     (c_out),
    .ovf       (ovf)
`ifdef CSEA_SERIAL_FLAGS_EN
    ,
    .zf        (zf),
    .nf        (nf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic with signed-overflow rules
  task automatic ref_model(input logic [63:0] a, input logic [63:0] b, input logic s,
                           output logic [63:0] ez, output logic ec, output logic eo);
    logic [64:0] full;
    if (!s) begin
      full = {1'b0, a} + {1'b0, b};
      ez   = full[63:0];
      ec   = full[64];
      eo   = (a[63] == b[63]) && (ez[63] != a[63]);
    end else begin
      ez   = a - b;
      ec   = (a >= b);
      eo   = (a[63] != b[63]) && (ez[63] != a[63]);
    end
  endtask

  // Wait for out_valid, returning cycles since the accept edge
  task automatic wait_result(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic chk_result(input logic [63:0] a, input logic [63:0] b, input logic s);
    logic [63:0] ez;
    logic        ec;
    logic        eo;
    ref_model(a, b, s, ez, ec, eo);
    chk_eq("z", z, ez);
    chk_eq("c_out", {63'd0, c_out}, {63'd0, ec});
    chk_eq("ovf", {63'd0, ovf}, {63'd0, eo});
`ifdef CSEA_SERIAL_FLAGS_EN
    chk_eq("zf", {63'd0, zf}, {63'd0, (ez == 64'd0)});
    chk_eq("nf", {63'd0, nf}, {63'd0, ez[63]});
`endif
  endtask

  // One full operation: accept, check latency and result, then drain
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s);
    int n;
    chk_eq("in_ready_idle", {63'd0, in_ready}, 64'd1);
    x = a; y = b; op_sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(n);
    chk_eq("latency", 64'(n), 64'd8);
    chk_result(a, b, s);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk_eq("out_valid_drop", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    logic [63:0] hold_z;
    logic        seen_valid;
    int          n;

    rst_b = 1'b0; in_valid = 1'b0; op_sub = 1'b0; x = '0; y = '0;
    flush = 1'b0; out_ready = 1'b0;
    #22;
    chk_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk_eq("rst_z", z, 64'd0);
    chk_eq("rst_c_out", {63'd0, c_out}, 64'd0);
    chk_eq("rst_ovf", {63'd0, ovf}, 64'd0);
    rst_b = 1'b1;
    @(posedge clk); #1;

    // Directed corner cases
    run_op(64'h0000_0000_0000_00FF, 64'h1, 1'b0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    run_op(64'h5, 64'h7, 1'b1);
    run_op(64'h7, 64'h5, 1'b1);
    run_op(64'h8000_0000_0000_0000, 64'h1, 1'b1);

    // Backpressure: result held while out_ready low, no accept in DONE
    x = 64'h1234_5678_9ABC_DEF0; y = 64'h0FED_CBA9_8765_4321; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(n);
    chk_eq("bp_latency", 64'(n), 64'd8);
    chk_result(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
    hold_z = z;
    x = 64'h1111; y = 64'h2222; op_sub = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk_eq("bp_z_stable", z, hold_z);
      chk_eq("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk_eq("bp_out_valid", {63'd0, out_valid}, 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk_eq("bp_release_valid", {63'd0, out_valid}, 64'd0);
    chk_eq("bp_release_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_eq("bp_accept", {63'd0, in_ready}, 64'd0);
    wait_result(n);
    chk_eq("bp2_latency", 64'(n), 64'd8);
    chk_result(64'h1111, 64'h2222, 1'b1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Flush on the fourth RUN cycle
    x = 64'hAAAA; y = 64'h5555; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk_eq("flush_idle", {63'd0, in_ready}, 64'd1);
    seen_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      seen_valid |= out_valid;
      @(posedge clk); #1;
    end
    chk_eq("flush_no_valid", {63'd0, seen_valid}, 64'd0);

    // flush in IDLE drops a simultaneous request
    x = 64'h9; y = 64'h9; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk_eq("flush_drop", {63'd0, in_ready}, 64'd1);

    // Asynchronous reset mid-RUN
    x = 64'hDEAD_BEEF; y = 64'h1; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_b = 1'b0;
    #1;
    chk_eq("arst_in_ready", {63'd0, in_ready}, 64'd1);
    chk_eq("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk_eq("arst_z", z, 64'd0);
    #3;
    rst_b = 1'b1;
    @(posedge clk); #1;
    run_op(64'd3, 64'd4, 1'b0);

    // Random operations
    for (int i = 0; i < 16; i++) begin
      run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
